// File: rtl/fp16_accumulator.sv
// fp16_accumulator: sums valid/ready streamed FP16 products per in_last-delimited group through an align/add/normalize FSM
module fp16_accumulator #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_data,
    output logic [COUNT_W-1:0] out_count
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t state_q, state_d;
    logic [15:0] op_q, op_d, acc_q, acc_d;
    logic last_q, last_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [13:0] big_q, big_d, small_q, small_d;
    logic [4:0] exp_q, exp_d;
    logic sign_q, sign_d, sub_q, sub_d, zsign_q, zsign_d, nan_q, nan_d, inf_q, inf_d;
    logic [14:0] sum_q, sum_d;

    logic [14:0] a_mag, b_mag;
    logic [15:0] hi, lo;
    logic [13:0] hi_ext, lo_ext, lo_sh, lost, lo_al;
    logic [4:0] shamt;
    logic a_nan, a_inf, b_nan, b_inf;
    logic [3:0] lead_pos;
    logic [13:0] norm;
    logic rnd_up;
    logic [10:0] mant;
    logic signed [6:0] res_exp;
    logic [15:0] res;

    // Unpack acc and operand (subnormals as signed zero), order by magnitude, align the smaller with sticky
    always_comb begin
        a_mag  = acc_q[14:10] == 5'd0 ? 15'd0 : acc_q[14:0];
        b_mag  = op_q[14:10] == 5'd0 ? 15'd0 : op_q[14:0];
        hi     = b_mag > a_mag ? {op_q[15], b_mag} : {acc_q[15], a_mag};
        lo     = b_mag > a_mag ? {acc_q[15], a_mag} : {op_q[15], b_mag};
        hi_ext = {hi[14:10] != 5'd0, hi[9:0], 3'b000};
        lo_ext = {lo[14:10] != 5'd0, lo[9:0], 3'b000};
        shamt  = hi[14:10] - lo[14:10];
        lo_sh  = lo_ext >> shamt;
        lost   = lo_ext & ~(14'h3fff << shamt);
        lo_al  = {lo_sh[13:1], lo_sh[0] | (|lost)};
        a_inf  = (&acc_q[14:10]) && acc_q[9:0] == 10'd0;
        a_nan  = (&acc_q[14:10]) && acc_q[9:0] != 10'd0;
        b_inf  = (&op_q[14:10]) && op_q[9:0] == 10'd0;
        b_nan  = (&op_q[14:10]) && op_q[9:0] != 10'd0;
    end

    // Leading-one normalize, round to nearest even, then resolve specials, zero, overflow and underflow
    always_comb begin
        lead_pos = 4'd0;
        for (int i = 0; i < 15; i++) if (sum_q[i]) lead_pos = 4'(i);
        norm    = 14'(sum_q << (4'd14 - lead_pos));
        rnd_up  = norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
        mant    = {1'b0, norm[13:4]} + {10'd0, rnd_up};
        res_exp = 7'(exp_q) + 7'(lead_pos) + 7'(mant[10]) - 7'd13;
        res     = nan_q ? 16'h7E00
                : inf_q ? {sign_q, 15'h7C00}
                : sum_q == 15'd0 ? {zsign_q, 15'd0}
                : res_exp >= 7'sd31 ? {sign_q, 15'h7C00}
                : res_exp <= 7'sd0 ? {sign_q, 15'd0}
                : {sign_q, res_exp[4:0], mant[9:0]};
    end

    // Datapath register updates for each FSM stage
    always_comb begin
        op_d    = op_q;
        last_d  = last_q;
        acc_d   = acc_q;
        count_d = count_q;
        big_d   = big_q;
        small_d = small_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        zsign_d = zsign_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        sum_d   = sum_q;
        if (state_q == IDLE && in_valid) begin
            op_d   = in_data;
            last_d = in_last;
        end
        if (state_q == ALIGN) begin
            big_d   = hi_ext;
            small_d = lo_al;
            exp_d   = hi[14:10];
            sign_d  = hi[15];
            sub_d   = hi[15] ^ lo[15];
            zsign_d = hi[15] & lo[15];
            nan_d   = a_nan | b_nan | (a_inf & b_inf & (acc_q[15] ^ op_q[15]));
            inf_d   = a_inf | b_inf;
        end
        if (state_q == ADD)
            sum_d = sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};
        if (state_q == NORM) begin
            acc_d   = res;
            count_d = &count_q ? count_q : count_q + COUNT_W'(1);
        end
        if (state_q == OUT && out_ready) begin
            acc_d   = 16'h0000;
            count_d = '0;
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 16'h0000;
            last_q  <= 1'b0;
            acc_q   <= 16'h0000;
            count_q <= '0;
            big_q   <= 14'd0;
            small_q <= 14'd0;
            exp_q   <= 5'd0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            zsign_q <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            sum_q   <= 15'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            big_q   <= big_d;
            small_q <= small_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            zsign_q <= zsign_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state sequencing through the fixed four-cycle accumulate pipeline
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = in_valid ? ALIGN : IDLE;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = last_q ? OUT : IDLE;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; result and count held in acc/count
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == OUT;
        out_data  = acc_q;
        out_count = count_q;
    end
endmodule

// File: tb/tb_fp16_accumulator.sv
// tb_fp16_accumulator: randomized and directed checks of fp16_accumulator against a real-arithmetic model
module tb_fp16_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic in_ready, out_valid, in_ready_s, out_valid_s;
    logic [15:0] out_data, out_data_s;
    logic [7:0] out_count;
    logic [1:0] out_count_s;
    int tests = 0;
    int fails = 0;
    logic [15:0] vals [16];

    fp16_accumulator #(.COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count)
    );

    fp16_accumulator #(.COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_count(out_count_s)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fval(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) return 0.0;
        m = (1024.0 + real'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] rnd16(input real s);
        logic sg;
        real m, sc, fl, fr;
        int e, fi;
        sg = s < 0.0;
        m = sg ? -s : s;
        e = 0;
        while (m >= pow2(e + 1)) e++;
        while (m < pow2(e)) e--;
        sc = m / pow2(e - 10);
        fl = $floor(sc);
        fr = sc - fl;
        fi = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && fi % 2 == 1)) fi++;
        if (fi == 2048) begin
            fi = 1024;
            e++;
        end
        if (e > 15) return {sg, 15'h7C00};
        if (e < -14) return {sg, 15'h0000};
        return {sg, 5'(e + 15), 10'(fi - 1024)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi;
        real s;
        an = a[14:10] == 5'h1f && a[9:0] != 10'd0;
        bn = b[14:10] == 5'h1f && b[9:0] != 10'd0;
        ai = a[14:10] == 5'h1f && a[9:0] == 10'd0;
        bi = b[14:10] == 5'h1f && b[9:0] == 10'd0;
        if (an || bn) return 16'h7E00;
        if (ai && bi) return a[15] == b[15] ? a : 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        s = fval(a) + fval(b);
        if (s == 0.0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
        return rnd16(s);
    endfunction

    function automatic logic [15:0] model_group(input int n);
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < n; i++) acc = fadd(acc, vals[i]);
        return acc;
    endfunction

    function automatic logic [15:0] rand_fp16();
        int r = $urandom_range(0, 19);
        logic s = 1'($urandom_range(0, 1));
        if (r == 0) return {s, 5'h1f, 10'($urandom_range(1, 1023))};
        if (r == 1) return {s, 15'h7C00};
        if (r == 2) return {s, 5'd0, 10'($urandom_range(0, 1023))};
        if (r < 12) return {s, 5'($urandom_range(12, 18)), 10'($urandom)};
        return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
    endfunction

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic recv(output logic [15:0] d, output logic [7:0] c, output logic [15:0] d2,
                        output logic [1:0] c2, output int lat);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL recv_timeout out_valid stayed %b, required 1", out_valid);
        end
        d = out_data;
        c = out_count;
        d2 = out_data_s;
        c2 = out_count_s;
        lat = n;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_group(input int n, output logic [15:0] d, output logic [7:0] c,
                             output logic [15:0] d2, output logic [1:0] c2);
        int lat;
        for (int i = 0; i < n; i++) send(vals[i], i == n - 1);
        recv(d, c, d2, c2, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 16'h0000, 8'd0}) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%h cnt=%0d, required 1 0 0000 0",
                     in_ready, out_valid, out_data, out_count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        int lat;
        send(16'h3C00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (in_ready !== (k == 3)) begin
                fails++;
                $display("FAIL basic_ready_gap k=%0d got %b, required %b", k, in_ready, k == 3);
            end
            @(posedge clk); #1;
        end
        send(16'h4000, 1'b1);
        recv(d, c, d2, c2, lat);
        tests++;
        if (d !== 16'h4200) begin
            fails++;
            $display("FAIL basic_data got %h, required 4200", d);
        end
        tests++;
        if (c !== 8'd2) begin
            fails++;
            $display("FAIL basic_count got %0d, required 2", c);
        end
        tests++;
        if (lat != 3) begin
            fails++;
            $display("FAIL basic_latency got %0d edges after accept edge, required 3", lat);
        end
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL basic_after_handshake got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        vals[0] = 16'h3C00;
        vals[1] = 16'h1000;
        run_group(2, d, c, d2, c2);
        tests++;
        if (d !== 16'h3C00) begin
            fails++;
            $display("FAIL round_tie_even_down got %h, required 3c00", d);
        end
        vals[0] = 16'h3C01;
        run_group(2, d, c, d2, c2);
        tests++;
        if (d !== 16'h3C02) begin
            fails++;
            $display("FAIL round_tie_even_up got %h, required 3c02", d);
        end
    endtask

    task automatic test_specials();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        logic [15:0] sa [5] = '{16'h7BFF, 16'h4200, 16'h7C00, 16'h7E00, 16'h0001};
        logic [15:0] sb [5] = '{16'h7BFF, 16'hC200, 16'hFC00, 16'h3C00, 16'h0000};
        logic [15:0] se [5] = '{16'h7C00, 16'h0000, 16'h7E00, 16'h7E00, 16'h0000};
        for (int k = 0; k < 5; k++) begin
            vals[0] = sa[k];
            vals[1] = sb[k];
            run_group(k == 4 ? 1 : 2, d, c, d2, c2);
            tests++;
            if (d !== se[k]) begin
                fails++;
                $display("FAIL specials case %0d got %h, required %h", k, d, se[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        int n = 0;
        send(16'h3C00, 1'b1);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_data = 16'h4400;
        in_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 16'h3C00, 8'd1}) begin
                fails++;
                $display("FAIL backpressure_hold cycle %0d got vld=%b rdy=%b data=%h cnt=%0d, required 1 0 3c00 1",
                         k, out_valid, in_ready, out_data, out_count);
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL backpressure_release got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        vals[0] = 16'h4000;
        run_group(1, d, c, d2, c2);
        tests++;
        if ({d, c} !== {16'h4000, 8'd1}) begin
            fails++;
            $display("FAIL backpressure_next_group got %h/%0d, required 4000/1", d, c);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        for (int i = 0; i < 5; i++) vals[i] = 16'h0000;
        run_group(5, d, c, d2, c2);
        tests++;
        if ({d2, c2} !== {16'h0000, 2'd3}) begin
            fails++;
            $display("FAIL saturation_w2 got %h/%0d, required 0000/3", d2, c2);
        end
        tests++;
        if ({d, c} !== {16'h0000, 8'd5}) begin
            fails++;
            $display("FAIL saturation_w8 got %h/%0d, required 0000/5", d, c);
        end
    endtask

    task automatic test_reset_mid_group();
        logic [15:0] d, d2;
        logic [7:0] c;
        logic [1:0] c2;
        send(16'h3C00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 16'h0000, 8'd0}) begin
            fails++;
            $display("FAIL midreset_async got rdy=%b vld=%b data=%h cnt=%0d, required 1 0 0000 0",
                     in_ready, out_valid, out_data, out_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        vals[0] = 16'h4000;
        run_group(1, d, c, d2, c2);
        tests++;
        if ({d, c} !== {16'h4000, 8'd1}) begin
            fails++;
            $display("FAIL midreset_group got %h/%0d, required 4000/1", d, c);
        end
    endtask

    task automatic test_random();
        logic [15:0] d, d2, e;
        logic [7:0] c;
        logic [1:0] c2;
        int n;
        for (int g = 0; g < 60; g++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) vals[i] = rand_fp16();
            e = model_group(n);
            run_group(n, d, c, d2, c2);
            tests++;
            if ({d, c} !== {e, 8'(n)}) begin
                fails++;
                $display("FAIL random group %0d n=%0d first=%h got %h/%0d, required %h/%0d",
                         g, n, vals[0], d, c, e, n);
            end
            tests++;
            if (c2 !== 2'(n > 3 ? 3 : n)) begin
                fails++;
                $display("FAIL random_sat_count group %0d got %0d, required %0d", g, c2, n > 3 ? 3 : n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_backpressure();
        test_saturation();
        test_reset_mid_group();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
